// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared cpu word type
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// rtl/data_path_muxs_pkg.sv - fetch state encoding and pc helper functions
package data_path_muxs_pkg;

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        REDIR_PEND = 2'd1,
        HALT       = 2'd2
    } fetch_state_t;

    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

    function automatic word_t seq_pc(input word_t addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating event counter used by fetch_ctrl performance monitors
module fetch_perf_cnt #(
    parameter int PERF_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] cnt_q;
    logic [PERF_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {PERF_W{1'b1}})) begin
            cnt_d = cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage pc sequencing controller (redirect buffering, halt)
// FETCH_PERF_EN builds the fetch/stall performance counters; otherwise they read 0.
module fetch_ctrl
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter word_t PC_INIT = 32'h00000000,
    parameter int    PERF_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  word_t             imemaddr,
    input  logic              ihit,
    input  logic              stall,
    input  logic              redirect,
    input  word_t             redirect_pc,
    input  logic              halt,
    output word_t             next_pc,
    output logic              enable_pc,
    output logic              imemREN,
    output logic              fetch_valid,
    output logic              flush_ifid,
    output logic              halted,
    output logic [PERF_W-1:0] perf_fetches,
    output logic [PERF_W-1:0] perf_stalls
);

    fetch_state_t state_q, state_d;
    word_t        pend_pc_q, pend_pc_d;
    logic         halted_q, halted_d;
    word_t        redir_tgt;

    assign redir_tgt = align_word(redirect_pc);

    always_comb begin
        state_d     = state_q;
        pend_pc_d   = pend_pc_q;
        halted_d    = halted_q;
        next_pc     = seq_pc(imemaddr);
        enable_pc   = 1'b0;
        imemREN     = 1'b1;
        fetch_valid = 1'b0;
        flush_ifid  = 1'b0;

        case (state_q)
            FETCH: begin
                if (halt) begin
                    flush_ifid = 1'b1;
                    state_d    = HALT;
                    halted_d   = 1'b1;
                end else if (redirect) begin
                    flush_ifid = 1'b1;
                    next_pc    = redir_tgt;
                    if (ihit) begin
                        enable_pc = 1'b1;
                    end else begin
                        // the in-flight read must land before the pc may move
                        pend_pc_d = redir_tgt;
                        state_d   = REDIR_PEND;
                    end
                end else if (!stall && ihit) begin
                    enable_pc   = 1'b1;
                    fetch_valid = 1'b1;
                end
            end

            REDIR_PEND: begin
                // whatever returns now is wrong-path, so the IF/ID latch takes a bubble
                flush_ifid = 1'b1;
                next_pc    = redirect ? redir_tgt : pend_pc_q;
                if (halt) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    if (redirect) begin
                        pend_pc_d = redir_tgt;
                    end
                    if (ihit) begin
                        enable_pc = 1'b1;
                        state_d   = FETCH;
                    end
                end
            end

            HALT: begin
                imemREN = 1'b0;
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= FETCH;
            pend_pc_q <= PC_INIT;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            halted_q  <= halted_d;
        end
    end

    assign halted = halted_q;

`ifdef FETCH_PERF_EN
    logic stall_inc;

    assign stall_inc = (state_q == FETCH) & ihit & stall & ~redirect & ~halt;

    fetch_perf_cnt #(.PERF_W(PERF_W)) u_fetch_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (fetch_valid),
        .count (perf_fetches)
    );

    fetch_perf_cnt #(.PERF_W(PERF_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc   (stall_inc),
        .count (perf_stalls)
    );
`else
    assign perf_fetches = '0;
    assign perf_stalls  = '0;
`endif

endmodule
